ula_serial_ctrl: RTL

- Sequencer that time-multiplexes one 1-bit ALU slice (`ULA` module) to run an N-bit operation bit-serially, LSB first.
- Owns operand and result shift registers, the carry flip-flop between slices, and the two-pass SLT (set-on-less-than) sequence.
- Used in area-reduced datapath variants where one slice replaces the N-slice ripple ALU.
- Start/busy/done handshake toward the core control unit.

---
 rtl/ula_serial_ctrl.sv | 202 ++++++++++++++++++++
 1 files changed

// File: rtl/ula_serial_ctrl.sv
// Bit-serial sequencer driving a single 1-bit ALU slice over N cycles, LSB first.
// Optional abort input and result shadow copy: define ULA_SERIAL_ABORT_EN.
module ula_serial_ctrl #(
    parameter int N = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         start,
    input  logic [N-1:0] opA,
    input  logic [N-1:0] opB,
    input  logic [2:0]   ALUop,
    input  logic         binvert,
`ifdef ULA_SERIAL_ABORT_EN
    input  logic         abort,
`endif
    output logic         busy,
    output logic         done,
    output logic [N-1:0] result,
    output logic         zero,
    output logic         overflow,
    output logic         slice_a,
    output logic         slice_b,
    output logic         slice_binvert,
    output logic         slice_cin,
    output logic         slice_less,
    output logic [2:0]   slice_op,
    input  logic         slice_result,
    input  logic         slice_cout,
    input  logic         slice_overf
);

    localparam int CW = (N > 2) ? $clog2(N) : 1;

    localparam logic [2:0] OP_AND = 3'b000;
    localparam logic [2:0] OP_ADD = 3'b010;
    localparam logic [2:0] OP_SLT = 3'b011;

    typedef enum logic [1:0] {
        S_IDLE,
        S_EXEC,
        S_LESS,
        S_DONE
    } state_t;

    state_t         state_q;
    logic [N-1:0]   a_q;
    logic [N-1:0]   b_q;
    logic [2:0]     op_q;
    logic           binv_q;
    logic [CW-1:0]  cnt_q;
    logic           carry_q;
    logic           set_q;
    logic [N-1:0]   result_q;
    logic           overflow_q;
    logic           busy_q;
    logic           done_q;
`ifdef ULA_SERIAL_ABORT_EN
    logic [N-1:0]   shadow_q;
`endif

    logic [N-1:0]   result_d;
    logic           last_bit;
    logic           is_slt;
    logic           active;

    assign last_bit = (cnt_q == CW'(N - 1));
    assign is_slt   = (op_q == OP_SLT);
    assign active   = (state_q == S_EXEC) || (state_q == S_LESS);

    // The current slice output lands in the bit selected by the counter.
    always_comb begin
        result_d        = result_q;
        result_d[cnt_q] = slice_result;
    end

    // Operands are rotated, so bit 0 is always the bit under the slice and
    // the originals are restored after N cycles for the second SLT pass.
    always_comb begin
        slice_a       = active & a_q[0];
        slice_b       = active & b_q[0];
        slice_binvert = active & (binv_q | is_slt);
        slice_cin     = active & carry_q;
        slice_less    = (state_q == S_LESS) && (cnt_q == '0) && set_q;
        slice_op      = OP_AND;
        if (state_q == S_EXEC) begin
            slice_op = is_slt ? OP_ADD : op_q;
        end else if (state_q == S_LESS) begin
            slice_op = OP_SLT;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            op_q       <= '0;
            binv_q     <= 1'b0;
            cnt_q      <= '0;
            carry_q    <= 1'b0;
            set_q      <= 1'b0;
            result_q   <= '0;
            overflow_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
`ifdef ULA_SERIAL_ABORT_EN
            shadow_q   <= '0;
`endif
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        a_q     <= opA;
                        b_q     <= opB;
                        op_q    <= ALUop;
                        binv_q  <= binvert;
                        cnt_q   <= '0;
                        carry_q <= binvert | (ALUop == OP_SLT);
`ifdef ULA_SERIAL_ABORT_EN
                        shadow_q <= result_q;
`endif
                        if (ALUop[2]) begin
                            result_q   <= '0;
                            overflow_q <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end else begin
                            busy_q  <= 1'b1;
                            state_q <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
`ifdef ULA_SERIAL_ABORT_EN
                    if (abort) begin
                        result_q <= shadow_q;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else
`endif
                    begin
                        result_q <= result_d;
                        carry_q  <= slice_cout;
                        cnt_q    <= cnt_q + CW'(1);
                        a_q      <= {a_q[0], a_q[N-1:1]};
                        b_q      <= {b_q[0], b_q[N-1:1]};
                        if (last_bit) begin
                            cnt_q <= '0;
                            if (is_slt) begin
                                // Sign of A-B corrected by overflow gives the true ordering.
                                set_q   <= slice_result ^ slice_overf;
                                state_q <= S_LESS;
                            end else begin
                                overflow_q <= (op_q == OP_ADD) & slice_overf;
                                busy_q     <= 1'b0;
                                done_q     <= 1'b1;
                                state_q    <= S_DONE;
                            end
                        end
                    end
                end
                S_LESS: begin
`ifdef ULA_SERIAL_ABORT_EN
                    if (abort) begin
                        result_q <= shadow_q;
                        busy_q   <= 1'b0;
                        state_q  <= S_IDLE;
                    end else
`endif
                    begin
                        result_q <= result_d;
                        cnt_q    <= cnt_q + CW'(1);
                        a_q      <= {a_q[0], a_q[N-1:1]};
                        b_q      <= {b_q[0], b_q[N-1:1]};
                        if (last_bit) begin
                            cnt_q      <= '0;
                            overflow_q <= 1'b0;
                            busy_q     <= 1'b0;
                            done_q     <= 1'b1;
                            state_q    <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign busy     = busy_q;
    assign done     = done_q;
    assign result   = result_q;
    assign overflow = overflow_q;
    assign zero     = (result_q == '0);

endmodule
